// File: rtl/mc_control_unit_if.sv
// Control-unit <-> datapath bundle: IR fields and flags in, datapath strobes/selects out.
// Latency: n/a (wires only). Backpressure: none, the datapath always follows the strobes.
// Ports: Op/Funct/Zero from datapath; PC_En..ALU_Control, State, Illegal, Instr_Count to datapath.
interface mc_control_unit_if #(
  parameter int CNT_W = 16
);
  logic [5:0]       Op;
  logic [5:0]       Funct;
  logic             Zero;
  logic             PC_En;
  logic             I_or_D;
  logic             Mem_Write;
  logic             IR_Write;
  logic             Reg_Write;
  logic             ALU_Src_A;
  logic [1:0]       Reg_Dst;
  logic [1:0]       Mem_to_Reg;
  logic [1:0]       ALU_Src_B;
  logic [1:0]       PC_Src;
  logic             Imm_Zext;
  logic [2:0]       ALU_Control;
  logic [3:0]       State;
  logic             Illegal;
  logic [CNT_W-1:0] Instr_Count;

  // Control unit side.
  modport slave (
    input  Op, Funct, Zero,
    output PC_En, I_or_D, Mem_Write, IR_Write, Reg_Write, ALU_Src_A,
           Reg_Dst, Mem_to_Reg, ALU_Src_B, PC_Src, Imm_Zext, ALU_Control,
           State, Illegal, Instr_Count
  );

  // Datapath side.
  modport master (
    output Op, Funct, Zero,
    input  PC_En, I_or_D, Mem_Write, IR_Write, Reg_Write, ALU_Src_A,
           Reg_Dst, Mem_to_Reg, ALU_Src_B, PC_Src, Imm_Zext, ALU_Control,
           State, Illegal, Instr_Count
  );
endinterface

// File: rtl/mc_control_unit.sv
// Multicycle MIPS-subset control FSM with sticky illegal flag and retired-instruction counter.
// Latency: 3 cycles (beq/bne/j/jal/jr), 4 (R-type, sw, I-type ALU), 5 (lw).
// Backpressure: none; ports are clk, reset (async active-low) and the bus interface (slave side).
module mc_control_unit #(
  parameter int CNT_W  = 16,
  parameter bit EN_EXT = 1'b1
) (
  input  logic         clk,
  input  logic         reset,
  mc_control_unit_if.slave bus
);

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXEC   = 4'd6,
    S_ALUWB  = 4'd7,
    S_BRANCH = 4'd8,
    S_IMMEX  = 4'd9,
    S_IMMWB  = 4'd10,
    S_JUMP   = 4'd11,
    S_JAL    = 4'd12,
    S_JR     = 4'd13
  } state_t;

  typedef struct packed {
    logic       pc_en;
    logic       i_or_d;
    logic       mem_write;
    logic       ir_write;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] reg_dst;
    logic [1:0] mem_to_reg;
    logic [1:0] alu_src_b;
    logic [1:0] pc_src;
    logic       imm_zext;
    logic [2:0] alu_control;
  } ctl_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_SLTI  = 6'b001010;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  localparam logic [5:0] F_JR  = 6'b001000;
  localparam logic [5:0] F_ADD = 6'b100000;
  localparam logic [5:0] F_SUB = 6'b100010;
  localparam logic [5:0] F_AND = 6'b100100;
  localparam logic [5:0] F_OR  = 6'b100101;
  localparam logic [5:0] F_SLT = 6'b101010;

  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_SLT = 3'b111;

  // Target of DECODE; anything not recognised (or extended while disabled) falls back to FETCH.
  function automatic state_t decode_target(input logic [5:0] op, input logic [5:0] funct);
    state_t s;
    s = S_FETCH;
    case (op)
      OP_LW, OP_SW: s = S_MEMADR;
      OP_RTYPE: begin
        case (funct)
          F_ADD, F_SUB, F_AND, F_OR, F_SLT: s = S_EXEC;
          F_JR:    s = EN_EXT ? S_JR : S_FETCH;
          default: s = S_FETCH;
        endcase
      end
      OP_BEQ:                    s = S_BRANCH;
      OP_BNE:                    s = EN_EXT ? S_BRANCH : S_FETCH;
      OP_ADDI:                   s = S_IMMEX;
      OP_ANDI, OP_ORI, OP_SLTI:  s = EN_EXT ? S_IMMEX : S_FETCH;
      OP_J:                      s = S_JUMP;
      OP_JAL:                    s = EN_EXT ? S_JAL : S_FETCH;
      default:                   s = S_FETCH;
    endcase
    return s;
  endfunction

  function automatic state_t next_state(input state_t s, input logic [5:0] op,
                                        input logic [5:0] funct);
    state_t n;
    case (s)
      S_FETCH:  n = S_DECODE;
      S_DECODE: n = decode_target(op, funct);
      S_MEMADR: n = (op == OP_SW) ? S_MEMWR : S_MEMRD;
      S_MEMRD:  n = S_MEMWB;
      S_EXEC:   n = S_ALUWB;
      S_IMMEX:  n = S_IMMWB;
      default:  n = S_FETCH;
    endcase
    return n;
  endfunction

  // Control word for a state. Op/Funct are stable in IR from DECODE onward, so the
  // word can be computed one edge early and registered.
  function automatic ctl_t ctl_for(input state_t s, input logic [5:0] op,
                                   input logic [5:0] funct);
    ctl_t c;
    c = '0;
    case (s)
      S_FETCH: begin
        c.ir_write = 1'b1; c.alu_src_b = 2'b01; c.alu_control = ALU_ADD; c.pc_en = 1'b1;
      end
      S_DECODE: begin
        c.alu_src_b = 2'b11; c.alu_control = ALU_ADD;
      end
      S_MEMADR: begin
        c.alu_src_a = 1'b1; c.alu_src_b = 2'b10; c.alu_control = ALU_ADD;
      end
      S_MEMRD: c.i_or_d = 1'b1;
      S_MEMWB: begin
        c.mem_to_reg = 2'b01; c.reg_write = 1'b1;
      end
      S_MEMWR: begin
        c.i_or_d = 1'b1; c.mem_write = 1'b1;
      end
      S_EXEC: begin
        c.alu_src_a = 1'b1;
        case (funct)
          F_SUB:   c.alu_control = ALU_SUB;
          F_AND:   c.alu_control = ALU_AND;
          F_OR:    c.alu_control = ALU_OR;
          F_SLT:   c.alu_control = ALU_SLT;
          default: c.alu_control = ALU_ADD;
        endcase
      end
      S_ALUWB: begin
        c.reg_dst = 2'b01; c.reg_write = 1'b1;
      end
      // PC_En for branches is resolved combinationally against Zero at the output.
      S_BRANCH: begin
        c.alu_src_a = 1'b1; c.alu_control = ALU_SUB; c.pc_src = 2'b01;
      end
      S_IMMEX: begin
        c.alu_src_a = 1'b1; c.alu_src_b = 2'b10;
        case (op)
          OP_ANDI: begin c.alu_control = ALU_AND; c.imm_zext = 1'b1; end
          OP_ORI:  begin c.alu_control = ALU_OR;  c.imm_zext = 1'b1; end
          OP_SLTI: c.alu_control = ALU_SLT;
          default: c.alu_control = ALU_ADD;
        endcase
      end
      S_IMMWB: c.reg_write = 1'b1;
      S_JUMP: begin
        c.pc_src = 2'b10; c.pc_en = 1'b1;
      end
      S_JAL: begin
        c.pc_src = 2'b10; c.pc_en = 1'b1; c.reg_dst = 2'b10; c.mem_to_reg = 2'b10;
        c.reg_write = 1'b1;
      end
      S_JR: begin
        c.pc_src = 2'b11; c.pc_en = 1'b1;
      end
      default: c = '0;
    endcase
    return c;
  endfunction

  function automatic logic is_terminal(input state_t s);
    return (s == S_MEMWB) || (s == S_MEMWR) || (s == S_ALUWB) || (s == S_BRANCH) ||
           (s == S_IMMWB) || (s == S_JUMP)  || (s == S_JAL)   || (s == S_JR);
  endfunction

  state_t           state;
  state_t           nxt;
  ctl_t             ctl;
  logic             illegal;
  logic [CNT_W-1:0] cnt;
  logic             br_take;

  assign nxt = next_state(state, bus.Op, bus.Funct);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= S_FETCH;
      ctl     <= ctl_for(S_FETCH, 6'd0, 6'd0);
      illegal <= 1'b0;
      cnt     <= '0;
    end else begin
      state <= nxt;
      ctl   <= ctl_for(nxt, bus.Op, bus.Funct);
      // Only an undecodable instruction takes DECODE straight back to FETCH.
      if (state == S_DECODE && nxt == S_FETCH) illegal <= 1'b1;
      if (is_terminal(state)) cnt <= cnt + 1'b1;
    end
  end

  // beq takes the branch on Zero, bne on !Zero.
  assign br_take = (state == S_BRANCH) && ((bus.Op == OP_BNE) ? !bus.Zero : bus.Zero);

  // Write strobes are held off for the whole time reset is low, not just until the next edge.
  assign bus.PC_En       = reset & (ctl.pc_en | br_take);
  assign bus.IR_Write    = reset & ctl.ir_write;
  assign bus.Mem_Write   = reset & ctl.mem_write;
  assign bus.Reg_Write   = reset & ctl.reg_write;
  assign bus.I_or_D      = ctl.i_or_d;
  assign bus.ALU_Src_A   = ctl.alu_src_a;
  assign bus.Reg_Dst     = ctl.reg_dst;
  assign bus.Mem_to_Reg  = ctl.mem_to_reg;
  assign bus.ALU_Src_B   = ctl.alu_src_b;
  assign bus.PC_Src      = ctl.pc_src;
  assign bus.Imm_Zext    = ctl.imm_zext;
  assign bus.ALU_Control = ctl.alu_control;
  assign bus.State       = state;
  assign bus.Illegal     = illegal;
  assign bus.Instr_Count = cnt;

endmodule

// File: tb/tb_mc_control_unit.sv
// Directed bench for mc_control_unit: one default instance, one with CNT_W=2 and EN_EXT=0.
// Latency: n/a. Backpressure: n/a.
// Ports: none; drives clk/reset and the master side of both interfaces.
module tb_mc_control_unit;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  mc_control_unit_if #(.CNT_W(16)) bus_a ();
  mc_control_unit_if #(.CNT_W(2))  bus_b ();

  mc_control_unit #(.CNT_W(16), .EN_EXT(1'b1)) dut_a (.clk(clk), .reset(reset), .bus(bus_a));
  mc_control_unit #(.CNT_W(2),  .EN_EXT(1'b0)) dut_b (.clk(clk), .reset(reset), .bus(bus_b));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b0;
    bus_a.Op = 6'd0; bus_a.Funct = 6'd0; bus_a.Zero = 1'b0;
    bus_b.Op = 6'd0; bus_b.Funct = 6'd0; bus_b.Zero = 1'b0;
    #12;
    chk("rst_state",   32'(bus_a.State), 32'd0);
    chk("rst_illegal", 32'(bus_a.Illegal), 32'd0);
    chk("rst_count",   32'(bus_a.Instr_Count), 32'd0);
    chk("rst_pc_en",   32'(bus_a.PC_En), 32'd0);
    chk("rst_ir_wr",   32'(bus_a.IR_Write), 32'd0);
    chk("rst_reg_wr",  32'(bus_a.Reg_Write), 32'd0);

    // lw
    bus_a.Op = 6'b100011;
    @(negedge clk); reset = 1'b1; #1;
    chk("fetch_state",  32'(bus_a.State), 32'd0);
    chk("fetch_pc_en",  32'(bus_a.PC_En), 32'd1);
    chk("fetch_ir_wr",  32'(bus_a.IR_Write), 32'd1);
    chk("fetch_srcb",   32'(bus_a.ALU_Src_B), 32'd1);
    chk("fetch_alu",    32'(bus_a.ALU_Control), 32'd2);
    tick();
    chk("lw_decode",    32'(bus_a.State), 32'd1);
    chk("decode_srcb",  32'(bus_a.ALU_Src_B), 32'd3);
    tick();
    chk("lw_memadr",    32'(bus_a.State), 32'd2);
    chk("memadr_srca",  32'(bus_a.ALU_Src_A), 32'd1);
    chk("memadr_srcb",  32'(bus_a.ALU_Src_B), 32'd2);
    tick();
    chk("lw_memrd",     32'(bus_a.State), 32'd3);
    chk("memrd_iord",   32'(bus_a.I_or_D), 32'd1);
    tick();
    chk("lw_memwb",     32'(bus_a.State), 32'd4);
    chk("memwb_regwr",  32'(bus_a.Reg_Write), 32'd1);
    chk("memwb_m2r",    32'(bus_a.Mem_to_Reg), 32'd1);
    chk("memwb_count",  32'(bus_a.Instr_Count), 32'd0);
    tick();
    chk("lw_done",      32'(bus_a.State), 32'd0);
    chk("lw_count",     32'(bus_a.Instr_Count), 32'd1);

    // bne
    bus_a.Op = 6'b000101; bus_a.Zero = 1'b0;
    tick(); tick();
    chk("bne_state",    32'(bus_a.State), 32'd8);
    chk("bne_pcsrc",    32'(bus_a.PC_Src), 32'd1);
    chk("bne_alu",      32'(bus_a.ALU_Control), 32'd6);
    chk("bne_z0_pcen",  32'(bus_a.PC_En), 32'd1);
    bus_a.Zero = 1'b1; #1;
    chk("bne_z1_pcen",  32'(bus_a.PC_En), 32'd0);
    tick();
    chk("bne_count",    32'(bus_a.Instr_Count), 32'd2);

    // beq
    bus_a.Op = 6'b000100; bus_a.Zero = 1'b1;
    tick(); tick();
    chk("beq_z1_pcen",  32'(bus_a.PC_En), 32'd1);
    bus_a.Zero = 1'b0; #1;
    chk("beq_z0_pcen",  32'(bus_a.PC_En), 32'd0);
    tick();
    chk("beq_count",    32'(bus_a.Instr_Count), 32'd3);

    // jal
    bus_a.Op = 6'b000011;
    tick(); tick();
    chk("jal_state",    32'(bus_a.State), 32'd12);
    chk("jal_pcsrc",    32'(bus_a.PC_Src), 32'd2);
    chk("jal_regdst",   32'(bus_a.Reg_Dst), 32'd2);
    chk("jal_m2r",      32'(bus_a.Mem_to_Reg), 32'd2);
    chk("jal_regwr",    32'(bus_a.Reg_Write), 32'd1);
    chk("jal_pcen",     32'(bus_a.PC_En), 32'd1);
    tick();
    chk("jal_done",     32'(bus_a.State), 32'd0);
    chk("jal_count",    32'(bus_a.Instr_Count), 32'd4);

    // R-type sub
    bus_a.Op = 6'b000000; bus_a.Funct = 6'b100010;
    tick(); tick();
    chk("sub_exec",     32'(bus_a.State), 32'd6);
    chk("sub_alu",      32'(bus_a.ALU_Control), 32'd6);
    tick();
    chk("sub_aluwb",    32'(bus_a.State), 32'd7);
    chk("aluwb_regdst", 32'(bus_a.Reg_Dst), 32'd1);
    chk("aluwb_regwr",  32'(bus_a.Reg_Write), 32'd1);
    tick();
    chk("sub_count",    32'(bus_a.Instr_Count), 32'd5);

    // jr
    bus_a.Funct = 6'b001000;
    tick(); tick();
    chk("jr_state",     32'(bus_a.State), 32'd13);
    chk("jr_pcsrc",     32'(bus_a.PC_Src), 32'd3);
    chk("jr_pcen",      32'(bus_a.PC_En), 32'd1);
    tick();
    chk("jr_count",     32'(bus_a.Instr_Count), 32'd6);

    // ori
    bus_a.Op = 6'b001101;
    tick(); tick();
    chk("ori_immex",    32'(bus_a.State), 32'd9);
    chk("ori_zext",     32'(bus_a.Imm_Zext), 32'd1);
    chk("ori_alu",      32'(bus_a.ALU_Control), 32'd1);
    chk("ori_srcb",     32'(bus_a.ALU_Src_B), 32'd2);
    tick();
    chk("ori_immwb",    32'(bus_a.State), 32'd10);
    chk("immwb_regwr",  32'(bus_a.Reg_Write), 32'd1);
    chk("immwb_zext",   32'(bus_a.Imm_Zext), 32'd0);
    tick();
    chk("ori_count",    32'(bus_a.Instr_Count), 32'd7);

    // illegal opcode
    bus_a.Op = 6'b111111;
    tick();
    chk("ill_decode",   32'(bus_a.State), 32'd1);
    chk("ill_pre_flag", 32'(bus_a.Illegal), 32'd0);
    tick();
    chk("ill_state",    32'(bus_a.State), 32'd0);
    chk("ill_flag",     32'(bus_a.Illegal), 32'd1);
    chk("ill_count",    32'(bus_a.Instr_Count), 32'd7);
    chk("ill_regwr",    32'(bus_a.Reg_Write), 32'd0);

    // addi afterwards: flag is sticky
    bus_a.Op = 6'b001000;
    tick(); tick();
    chk("addi_alu",     32'(bus_a.ALU_Control), 32'd2);
    chk("addi_zext",    32'(bus_a.Imm_Zext), 32'd0);
    tick(); tick();
    chk("addi_count",   32'(bus_a.Instr_Count), 32'd8);
    chk("ill_sticky",   32'(bus_a.Illegal), 32'd1);

    // sw, reset while in MEMWR
    bus_a.Op = 6'b101011;
    tick(); tick(); tick();
    chk("sw_memwr",     32'(bus_a.State), 32'd5);
    chk("sw_memwrite",  32'(bus_a.Mem_Write), 32'd1);
    chk("sw_iord",      32'(bus_a.I_or_D), 32'd1);
    #2 reset = 1'b0;
    #1;
    chk("rstmid_memwr", 32'(bus_a.Mem_Write), 32'd0);
    chk("rstmid_state", 32'(bus_a.State), 32'd0);
    chk("rstmid_count", 32'(bus_a.Instr_Count), 32'd0);
    chk("rstmid_ill",   32'(bus_a.Illegal), 32'd0);

    // Second instance: andi is illegal with extensions off.
    bus_b.Op = 6'b001100;
    @(negedge clk); reset = 1'b1; #1;
    tick();
    chk("a_post_rst",   32'(bus_a.State), 32'd1);
    chk("b_andi_dec",   32'(bus_b.State), 32'd1);
    tick();
    chk("b_andi_state", 32'(bus_b.State), 32'd0);
    chk("b_andi_ill",   32'(bus_b.Illegal), 32'd1);
    chk("b_andi_count", 32'(bus_b.Instr_Count), 32'd0);

    // Five addi on a 2-bit counter: 1,2,3,0,1.
    bus_b.Op = 6'b001000;
    for (int i = 0; i < 5; i++) begin
      repeat (4) tick();
      chk("b_addi_count", 32'(bus_b.Instr_Count), 32'((i + 1) % 4));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
